// File: rtl/serial_subtractor_if.sv
// Start/operand/result bundle for serial_subtractor. The master drives the
// request, the slave returns the result. `mode` exists only with ADDSUB_MODE_EN.
interface serial_subtractor_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             bin;
`ifdef ADDSUB_MODE_EN
   logic             mode;
`endif
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] diff;
   logic             bout;

   modport master (
`ifdef ADDSUB_MODE_EN
      output mode,
`endif
      output start, a, b, bin,
      input  busy, done, diff, bout
   );

   modport slave (
`ifdef ADDSUB_MODE_EN
      input  mode,
`endif
      input  start, a, b, bin,
      output busy, done, diff, bout
   );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial a - b - bin, LSB first, through a single borrow flop.
// Define ADDSUB_MODE_EN to add a `mode` input selecting add (0) or subtract (1).
module serial_subtractor #(
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst,
   serial_subtractor_if.slave bus
);
   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] sa_q, sa_d, sb_q, sb_d, res_q, res_d;
   logic [WIDTH-1:0] diff_q, diff_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             br_q, br_d, bout_q, bout_d;
   logic             busy_q, busy_d, done_q, done_d;
   logic             sub, a_eff, d_bit, br_next;
`ifdef ADDSUB_MODE_EN
   logic             mode_q, mode_d;
   assign sub = mode_q;
`else
   assign sub = 1'b1;
`endif

   // Subtract is an add with the minuend bit inverted in the borrow term.
   assign a_eff   = sub ? ~sa_q[0] : sa_q[0];
   assign d_bit   = sa_q[0] ^ sb_q[0] ^ br_q;
   assign br_next = (a_eff & sb_q[0]) | (a_eff & br_q) | (sb_q[0] & br_q);

   always_comb begin
      // NOTE: every _d gets a default first so no path leaves it unassigned (no latches).
      state_d = state_q;
      sa_d    = sa_q;
      sb_d    = sb_q;
      res_d   = res_q;
      br_d    = br_q;
      cnt_d   = cnt_q;
      diff_d  = diff_q;
      bout_d  = bout_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
`ifdef ADDSUB_MODE_EN
      mode_d  = mode_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (bus.start) begin
               state_d = RUN;
               sa_d    = bus.a;
               sb_d    = bus.b;
               br_d    = bus.bin;
               cnt_d   = '0;
               busy_d  = 1'b1;
`ifdef ADDSUB_MODE_EN
               mode_d  = bus.mode;
`endif
            end
         end
         RUN: begin
            sa_d  = sa_q >> 1;
            sb_d  = sb_q >> 1;
            res_d = {d_bit, res_q[WIDTH-1:1]};
            br_d  = br_next;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == LAST) begin
               state_d = DONE;
               diff_d  = {d_bit, res_q[WIDTH-1:1]};
               bout_d  = br_next;
               done_d  = 1'b1;
            end
         end
         DONE: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         sa_q    <= '0;
         sb_q    <= '0;
         res_q   <= '0;
         br_q    <= 1'b0;
         cnt_q   <= '0;
         diff_q  <= '0;
         bout_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
`ifdef ADDSUB_MODE_EN
         mode_q  <= 1'b1;
`endif
      end else begin
         // NOTE: non-blocking here so every flop samples pre-edge values together.
         state_q <= state_d;
         sa_q    <= sa_d;
         sb_q    <= sb_d;
         res_q   <= res_d;
         br_q    <= br_d;
         cnt_q   <= cnt_d;
         diff_q  <= diff_d;
         bout_q  <= bout_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
`ifdef ADDSUB_MODE_EN
         mode_q  <= mode_d;
`endif
      end
   end

   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.diff = diff_q;
   assign bus.bout = bout_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// Randomized self-checking bench for serial_subtractor against an arithmetic
// reference model; exercises latency, held start, and mid-operation reset.
module tb_serial_subtractor;
   localparam int W = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_pass  = 0;
   int   n_total = 0;
   logic [W-1:0] last_diff = '0;
   logic         last_bout = 1'b0;

   serial_subtractor_if #(.WIDTH(W)) bus ();
   serial_subtractor #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      if (obs !== exp) $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      else n_pass++;
   endtask

   // Reference: plain integer arithmetic on the operands.
   task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                        input logic md, output logic [W-1:0] ed, output logic eb);
      int ia, ib, ic, r;
      ia = int'(a); ib = int'(b); ic = int'(bin);
      if (md) begin
         r  = ia - ib - ic;
         eb = (ia < ib + ic);
      end else begin
         r  = ia + ib + ic;
         eb = (r >= (1 << W));
      end
      ed = W'(r & ((1 << W) - 1));
   endtask

   task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                        input logic md);
      bus.a   = a;
      bus.b   = b;
      bus.bin = bin;
`ifdef ADDSUB_MODE_EN
      bus.mode = md;
`endif
   endtask

   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                         input logic md, input string tag);
      logic [W-1:0] ed;
      logic         eb;
      int done_at, done_cnt, busy_cnt;
      model(a, b, bin, md, ed, eb);
      @(negedge clk);
      drive(a, b, bin, md);
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      drive(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
      done_at = -1; done_cnt = 0; busy_cnt = 0;
      for (int k = 0; k <= W + 3; k++) begin
         if (k > 0) begin @(posedge clk); #1; end
         if (bus.busy) busy_cnt++;
         if (bus.done) begin
            done_cnt++;
            if (done_at < 0) done_at = k;
         end
         if (k == W - 1) check({tag, "_diff_hold"}, 32'(bus.diff), 32'(last_diff));
      end
      check({tag, "_done_at"}, 32'(done_at), 32'(W));
      check({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
      check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(W + 1));
      check({tag, "_diff"}, 32'(bus.diff), 32'(ed));
      check({tag, "_bout"}, 32'(bus.bout), 32'(eb));
      last_diff = ed;
      last_bout = eb;
   endtask

   initial begin
      int dcnt;
      bus.start = 1'b0;
      drive('0, '0, 1'b0, 1'b1);

      #2;
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_done", 32'(bus.done), 32'd0);
      check("rst_diff", 32'(bus.diff), 32'd0);
      check("rst_bout", 32'(bus.bout), 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      run_op(8'd100, 8'd37, 1'b0, 1'b1, "basic");
      run_op(8'd5, 8'd10, 1'b0, 1'b1, "neg");
      run_op(8'd0, 8'd0, 1'b1, 1'b1, "zero_bin");
      run_op(8'hFF, 8'hFF, 1'b1, 1'b1, "max_bin");
      run_op(8'hFF, 8'h00, 1'b0, 1'b1, "max_zero");

      // Held start: operands changed mid-run must not affect the captured ones.
      @(negedge clk);
      drive(8'd9, 8'd4, 1'b0, 1'b1);
      bus.start = 1'b1;
      @(posedge clk); #1;
      for (int k = 0; k <= 20; k++) begin
         if (k > 0) begin @(posedge clk); #1; end
         if (k == 3) bus.a = 8'd200;
         if (k == 8) begin
            check("hold_done1", 32'(bus.done), 32'd1);
            check("hold_diff1", 32'(bus.diff), 32'd5);
         end
         if (k == 9)  check("hold_busy_gap", 32'(bus.busy), 32'd0);
         if (k == 10) check("hold_reaccept", 32'(bus.busy), 32'd1);
         if (k == 18) begin
            check("hold_done2", 32'(bus.done), 32'd1);
            check("hold_diff2", 32'(bus.diff), 32'd196);
            bus.start = 1'b0;
         end
      end
      last_diff = 8'd196;
      last_bout = 1'b0;

      // Reset in the middle of RUN.
      @(negedge clk);
      drive(8'd77, 8'd12, 1'b0, 1'b1);
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (4) @(posedge clk);
      #1 rst = 1'b1;
      #1;
      check("abort_busy", 32'(bus.busy), 32'd0);
      check("abort_done", 32'(bus.done), 32'd0);
      check("abort_diff", 32'(bus.diff), 32'd0);
      check("abort_bout", 32'(bus.bout), 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      dcnt = 0;
      for (int k = 0; k < W + 4; k++) begin
         @(posedge clk); #1;
         if (bus.done) dcnt++;
      end
      check("abort_no_done", 32'(dcnt), 32'd0);
      last_diff = '0;
      last_bout = 1'b0;
      run_op(8'd77, 8'd12, 1'b0, 1'b1, "post_rst");

`ifdef ADDSUB_MODE_EN
      run_op(8'd200, 8'd100, 1'b1, 1'b0, "add");
      run_op(8'd200, 8'd100, 1'b1, 1'b1, "sub");
`endif

      for (int i = 0; i < 24; i++) begin
         logic md;
`ifdef ADDSUB_MODE_EN
         md = 1'($urandom);
`else
         md = 1'b1;
`endif
         run_op(W'($urandom), W'($urandom), 1'($urandom), md, $sformatf("rnd%0d", i));
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial subtractor that computes `a - b - bin` one bit per clock, LSB first, using a single borrow flip-flop. It is the subtracting counterpart to the team's ripple adder cells. It serves datapaths that trade latency for area. Operands are loaded in parallel on a start handshake; the result and borrow-out are presented in parallel with a one-cycle `done` pulse.

## Interface
- `WIDTH`, default 8: operand/result width in bits; legal range 2..32.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `start` input 1: request; sampled only in IDLE.
- `a` input WIDTH: minuend; captured on the accepted start.
- `b` input WIDTH: subtrahend; captured on the accepted start.
- `bin` input 1: borrow-in; captured on the accepted start.
- `mode` input 1: operation select; present only with `ADDSUB_MODE_EN`; 1 = subtract, 0 = add.
- `busy` output 1: high in RUN and DONE.
- `done` output 1: one-cycle pulse when the result is valid.
- `diff` output WIDTH: result; holds its value until the next completion.
- `bout` output 1: final borrow-out (carry-out in add mode); holds its value until the next completion.

## Operation
- States: IDLE, RUN, DONE.
- **IDLE → RUN:** on `start`=1 at a clock edge.
  - Load shift registers `sa`=`a`, `sb`=`b`.
  - Borrow flop `br`=`bin`.
  - Bit counter `cnt`=0.
- **RUN, each edge:**
  - Per-bit function: `d` = `sa[0]^sb[0]^br`; `br_next` = `(~sa[0]&sb[0]) | (~sa[0]&br) | (sb[0]&br)`.
  - Shift `sa` and `sb` right by one.
  - Shift `d` into the result shift register at the MSB.
  - `cnt` += 1.
- **RUN → DONE:** on the edge that processes bit WIDTH-1 (`cnt`==WIDTH-1).
  - `diff` ← completed result register.
  - `bout` ← `br_next`.
- **DONE → IDLE:** unconditionally after one cycle.
- Arithmetic: `diff` = (`a` − `b` − `bin`) mod 2^WIDTH. `bout`=1 exactly when `a` < `b` + `bin` (unsigned).
- `start` is ignored in RUN and DONE. Operand inputs may change freely after the accepted edge.
- `diff` and `bout` change only on the RUN→DONE edge. Intermediate shifting is not visible on them.
- `cnt` width is `$clog2(WIDTH)`. No wrap-around occurs inside one operation.

## Timing
- Reset values, applied immediately and asynchronously:
  - state = IDLE.
  - `busy`=0, `done`=0, `diff`=0, `bout`=0.
  - Internal registers cleared.
- Reset asserted mid-operation aborts the operation. No `done` is produced, and `diff`/`bout` read 0 after reset.
- Latency, with `start` accepted at edge E:
  - `busy` rises after E.
  - `diff`/`bout` are updated at edge E+WIDTH.
  - `done` is high during the cycle between E+WIDTH and E+WIDTH+1.
  - `busy` falls after E+WIDTH+1.
- Earliest back-to-back `start` acceptance is edge E+WIDTH+2, giving a throughput of one operation per WIDTH+2 cycles.
- Outputs are registered; there are no combinational input-to-output paths.

## Configuration
- `ADDSUB_MODE_EN` defined:
  - `mode` port exists and is captured on the accepted start.
  - When `mode`=0, the per-bit function becomes a full add: `d` = `sa[0]^sb[0]^br`, `br_next` = `(sa[0]&sb[0]) | (sa[0]&br) | (sb[0]&br)`.
  - In add mode, `bin` acts as carry-in and `bout` as carry-out.
  - When `mode`=1, behaviour is the subtract function described above.
- `ADDSUB_MODE_EN` undefined: no `mode` port; subtract only. Timing is identical in both builds.

## Test plan
- WIDTH=8, `a`=100, `b`=37, `bin`=0, `start` pulse at edge E → `diff`=63, `bout`=0; `done` high exactly one cycle after edge E+8; `busy` high for 9 cycles.
- `a`=5, `b`=10, `bin`=0 → `diff`=8'hFB, `bout`=1. Separately, `a`=0, `b`=0, `bin`=1 → `diff`=8'hFF, `bout`=1.
- Hold `start`=1 continuously with `a`=9, `b`=4, changing `a` to 200 at E+3 → first result is `diff`=5; the next acceptance occurs at E+10; `start` is ignored while `busy`.
- Assert `rst` at E+4 during RUN → `busy`, `done`, `diff`, `bout` go to 0 immediately; no `done` pulse follows; a new `start` after reset release gives a correct result.
- With `ADDSUB_MODE_EN`: `mode`=0, `a`=200, `b`=100, `bin`=1 → `diff`=45, `bout`=1. Then `mode`=1 with the same operands → `diff`=99, `bout`=0.
